systolic_array_writeback: RTL and testbench
===========================================

# systolic_array_writeback

- Downstream stage of the systolic array controller.
- On each tile-complete pulse it snapshots the TILE_DIM×TILE_DIM accumulator tile and reads the per-column bias words.
- Each element goes through bias add, arithmetic right shift, optional ReLU and saturation to DATA_WIDTH.
- Results are written row-major into the output single-port RAM at the tile's position in the output matrix; a one-cycle `done` pulse signals completion.

## Interface

Parameters:
- TILE_DIM, 2, tile edge length.
- DATA_WIDTH, 8, output/bias element width; accumulators are 2*DATA_WIDTH.
- ADDR_WIDTH, 16, RAM address width.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset; synchronous, active-low.
- start  in  1  tile-ready pulse (driven from the controller's sa_done).
- acc_in  in  TILE_DIM*TILE_DIM*2*DATA_WIDTH  signed accumulators, declared [0:...]; element e=r*TILE_DIM+c at [e*2*DATA_WIDTH +: 2*DATA_WIDTH].
- blk_row_idx, blk_col_idx  in  32  tile coordinates.
- out_stride  in  32  output-matrix row pitch in elements.
- shift  in  $clog2(2*DATA_WIDTH)  requant right-shift amount.
- relu_en  in  1  clamp negative results to 0.
- bias_en  out  1  bias RAM read strobe.
- bias_addr  out  ADDR_WIDTH  bias RAM address.
- bias_rdata  in  DATA_WIDTH  signed bias word; 1-cycle read latency.
- out_we  out  1  output RAM write strobe.
- out_addr  out  ADDR_WIDTH  output RAM address.
- out_wdata  out  DATA_WIDTH  output RAM data.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.

## Operation

States: IDLE, BIAS, WRITE, DONE.
- **IDLE:**
  - On `start`=1, latch all of acc_in, blk_row_idx, blk_col_idx, out_stride, shift and relu_en into internal registers.
  - Go to BIAS.
  - `start` is ignored in every other state; it is not queued.
- **BIAS:**
  - TILE_DIM+1 cycles.
  - Cycles 0..TILE_DIM-1 drive bias_en=1, bias_addr = blk_col_idx*TILE_DIM + c for c = 0,1,...
  - Each bias_rdata is captured one cycle after its request into bias_reg[c].
  - Last cycle: capture only, then go to WRITE.
- **WRITE:** TILE_DIM² cycles, one write per cycle, row-major (r outer, c inner). Element (r,c):
  - sum = sext(acc[r][c]) + sext(bias_reg[c]) at 2*DATA_WIDTH+1 bits (no intermediate overflow).
  - sh = sum >>> shift (arithmetic, floor).
  - If relu_en and sh<0, sh=0.
  - Saturate sh to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - Drive out_we=1, out_addr = (blk_row_idx*TILE_DIM + r)*out_stride + blk_col_idx*TILE_DIM + c, out_wdata = saturated sh.
- **DONE:** done=1 for one cycle, then go to IDLE.
- Address arithmetic is done at 32 bits and truncated modulo 2^ADDR_WIDTH; out-of-range addresses wrap without error.
- Only latched values are used after `start`, so the upstream may change acc_in and the indices during BIAS/WRITE.

## Timing

- Reset (rstn=0 at a clock edge) puts the block in IDLE:
  - busy, done, out_we, bias_en = 0.
  - out_addr, bias_addr, out_wdata = 0.
  - Internal registers = 0.
- Reset asserted mid-operation takes effect at the next edge: any pending writes are abandoned and no `done` pulse is issued.
- `start` sampled at edge T:
  - busy=1 from T+1.
  - bias_en during T+1..T+TILE_DIM.
  - out_we during T+TILE_DIM+2 .. T+TILE_DIM+1+TILE_DIM².
  - done=1 at T+TILE_DIM+TILE_DIM²+2.
  - For TILE_DIM=2: writes in cycles T+4..T+7, done at T+8.
- busy falls in the cycle after done; a new `start` is accepted in that IDLE cycle, giving TILE_DIM²+TILE_DIM+3 cycles per tile back to back.
- out_we and bias_en are never high in the same cycle.
- Outputs are registered, with no combinational path from any input to any output.

## Test plan

All scenarios use TILE_DIM=2, DATA_WIDTH=8, ADDR_WIDTH=16.

1. **Reset:** hold rstn=0 for 3 cycles with start=1 -> all outputs 0, no out_we or bias_en; after release with start=0, busy stays 0.
2. **Basic tile:**
   - Stimulus: blk(0,0), stride 4, shift 0, relu off, bias[0]=1, bias[1]=-2, acc=[10,20,30,40].
   - Response: bias reads at addr 0,1; writes (0:11), (1:18), (4:31), (5:38) in cycles T+4..T+7; done at T+8.
3. **Saturation and shift:**
   - Stimulus: acc=[1000,-1000,32767,-32768], bias 127,127 (shift 2) -> expect 127, -128, 127, -128.
   - Then acc=[9,-9,-8,0], bias 0, shift 1, relu off -> expect 4, -5, -4, 0.
   - Repeat with relu on -> expect 4, 0, 0, 0.
4. **Addressing:** blk(1,1), stride 4 -> bias addrs 2,3; write addrs 10,11,14,15. blk(0,0x7FFF), stride 0 -> write addrs 0xFFFE, 0xFFFF, 0xFFFE, 0xFFFF (wrap).
5. **Snapshot and ignore:**
   - Change acc_in and blk_row_idx at T+1, and pulse start at T+3 -> writes still use the T-latched values; exactly 4 writes and 1 done.
   - Start at T+9 (IDLE after done) -> a second tile is accepted.
6. **Reset mid-WRITE:** assert rstn=0 at T+5 -> out_we=0 from T+6, done never pulses, and only the writes issued before reset were performed.

Source files
------------

// File: rtl/systolic_array_writeback.sv
// Writeback stage of the systolic array: snapshots an accumulator tile, adds per-column bias,
// requantizes (shift, optional ReLU, saturate) and writes the tile row-major into the output RAM.
module systolic_array_writeback #(
  parameter int TILE_DIM   = 2,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                                      clk,
  input  logic                                      rstn,
  input  logic                                      start,
  input  logic [0:TILE_DIM*TILE_DIM*2*DATA_WIDTH-1] acc_in,
  input  logic [31:0]                               blk_row_idx,
  input  logic [31:0]                               blk_col_idx,
  input  logic [31:0]                               out_stride,
  input  logic [$clog2(2*DATA_WIDTH)-1:0]           shift,
  input  logic                                      relu_en,
  output logic                                      bias_en,
  output logic [ADDR_WIDTH-1:0]                     bias_addr,
  input  logic [DATA_WIDTH-1:0]                     bias_rdata,
  output logic                                      out_we,
  output logic [ADDR_WIDTH-1:0]                     out_addr,
  output logic [DATA_WIDTH-1:0]                     out_wdata,
  output logic                                      busy,
  output logic                                      done
);

  localparam int AW  = 2 * DATA_WIDTH;
  localparam int SW  = AW + 1;
  localparam int NE  = TILE_DIM * TILE_DIM;
  localparam int CW  = $clog2(NE + 1);
  localparam int IW  = (TILE_DIM > 1) ? $clog2(TILE_DIM) : 1;
  localparam int SHW = $clog2(AW);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BIAS  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic signed [SW-1:0]  SAT_MAX = SW'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [SW-1:0]  SAT_MIN = SW'(-(1 << (DATA_WIDTH - 1)));
  localparam logic [DATA_WIDTH-1:0] OUT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] OUT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [1:0]                   state;
  logic [CW-1:0]                cnt;
  logic [IW-1:0]                r_idx;
  logic [IW-1:0]                c_idx;
  logic signed [AW-1:0]         acc_q  [NE];
  logic signed [DATA_WIDTH-1:0] bias_q [TILE_DIM];
  logic [31:0]                  row_q;
  logic [31:0]                  col_q;
  logic [31:0]                  stride_q;
  logic [SHW-1:0]               shift_q;
  logic                         relu_q;

  logic signed [AW-1:0]         acc_e;
  logic signed [DATA_WIDTH-1:0] bias_e;
  logic signed [SW-1:0]         sum;
  logic signed [SW-1:0]         sh;
  logic signed [SW-1:0]         clip;
  logic [DATA_WIDTH-1:0]        elem_data;
  logic [ADDR_WIDTH-1:0]        elem_addr;
  logic [ADDR_WIDTH-1:0]        first_bias_addr;
  logic [ADDR_WIDTH-1:0]        next_bias_addr;

  always_comb begin
    acc_e = '0;
    for (int unsigned r = 0; r < TILE_DIM; r++)
      for (int unsigned c = 0; c < TILE_DIM; c++)
        if (r_idx == IW'(r) && c_idx == IW'(c)) acc_e = acc_q[r*TILE_DIM + c];
    bias_e = '0;
    for (int unsigned c = 0; c < TILE_DIM; c++)
      if (c_idx == IW'(c)) bias_e = bias_q[c];
    // With a single column the last bias word lands on the same edge element 0 is formed.
    if (state == S_BIAS && c_idx == IW'(TILE_DIM - 1)) bias_e = bias_rdata;

    sum  = $signed({acc_e[AW-1], acc_e}) +
           $signed({{(SW-DATA_WIDTH){bias_e[DATA_WIDTH-1]}}, bias_e});
    sh   = sum >>> shift_q;
    clip = (relu_q && sh[SW-1]) ? '0 : sh;
    if (clip > SAT_MAX)      elem_data = OUT_MAX;
    else if (clip < SAT_MIN) elem_data = OUT_MIN;
    else                     elem_data = clip[DATA_WIDTH-1:0];

    elem_addr = ADDR_WIDTH'((row_q * 32'(TILE_DIM) + 32'(r_idx)) * stride_q
                            + col_q * 32'(TILE_DIM) + 32'(c_idx));
    first_bias_addr = ADDR_WIDTH'(blk_col_idx * 32'(TILE_DIM));
    next_bias_addr  = ADDR_WIDTH'(col_q * 32'(TILE_DIM) + 32'(cnt) + 32'd1);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= S_IDLE;
      cnt       <= '0;
      r_idx     <= '0;
      c_idx     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      stride_q  <= '0;
      shift_q   <= '0;
      relu_q    <= 1'b0;
      for (int unsigned e = 0; e < NE; e++) acc_q[e] <= '0;
      for (int unsigned c = 0; c < TILE_DIM; c++) bias_q[c] <= '0;
      bias_en   <= 1'b0;
      bias_addr <= '0;
      out_we    <= 1'b0;
      out_addr  <= '0;
      out_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            for (int unsigned e = 0; e < NE; e++) acc_q[e] <= acc_in[e*AW +: AW];
            row_q     <= blk_row_idx;
            col_q     <= blk_col_idx;
            stride_q  <= out_stride;
            shift_q   <= shift;
            relu_q    <= relu_en;
            cnt       <= '0;
            r_idx     <= '0;
            c_idx     <= '0;
            bias_en   <= 1'b1;
            bias_addr <= first_bias_addr;
            busy      <= 1'b1;
            state     <= S_BIAS;
          end
        end
        S_BIAS: begin
          // Data for the request issued at count k arrives while the count is k+1.
          for (int unsigned c = 0; c < TILE_DIM; c++)
            if (cnt == CW'(c + 1)) bias_q[c] <= bias_rdata;
          if (cnt < CW'(TILE_DIM - 1)) begin
            bias_en   <= 1'b1;
            bias_addr <= next_bias_addr;
            cnt       <= cnt + CW'(1);
          end else if (cnt == CW'(TILE_DIM - 1)) begin
            bias_en <= 1'b0;
            cnt     <= cnt + CW'(1);
          end else begin
            out_we    <= 1'b1;
            out_addr  <= elem_addr;
            out_wdata <= elem_data;
            if (c_idx == IW'(TILE_DIM - 1)) begin
              c_idx <= '0;
              r_idx <= r_idx + IW'(1);
            end else begin
              c_idx <= c_idx + IW'(1);
            end
            cnt   <= CW'(1);
            state <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (cnt < CW'(NE)) begin
            out_we    <= 1'b1;
            out_addr  <= elem_addr;
            out_wdata <= elem_data;
            if (c_idx == IW'(TILE_DIM - 1)) begin
              c_idx <= '0;
              r_idx <= r_idx + IW'(1);
            end else begin
              c_idx <= c_idx + IW'(1);
            end
            cnt <= cnt + CW'(1);
          end else begin
            out_we <= 1'b0;
            done   <= 1'b1;
            state  <= S_DONE;
          end
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_array_writeback.sv
// Randomized self-checking bench for systolic_array_writeback: cycle-exact expectations from a
// behavioural requantization/addressing model and a 1-cycle-latency bias RAM model.
module tb_systolic_array_writeback;

  localparam int TD = 2;
  localparam int DW = 8;
  localparam int AW = 16;
  localparam int NE = TD * TD;

  logic              clk = 1'b0;
  logic              rstn;
  logic              start;
  logic [0:NE*2*DW-1] acc_in;
  logic [31:0]       blk_row_idx;
  logic [31:0]       blk_col_idx;
  logic [31:0]       out_stride;
  logic [3:0]        shift;
  logic              relu_en;
  logic              bias_en;
  logic [AW-1:0]     bias_addr;
  logic [DW-1:0]     bias_rdata;
  logic              out_we;
  logic [AW-1:0]     out_addr;
  logic [DW-1:0]     out_wdata;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] bias_mem [0:65535];

  int          t_acc  [NE];
  int          t_bias [TD];
  int unsigned t_row, t_col, t_stride;
  int          t_shift;
  bit          t_relu;

  systolic_array_writeback #(
    .TILE_DIM  (TD),
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .acc_in     (acc_in),
    .blk_row_idx(blk_row_idx),
    .blk_col_idx(blk_col_idx),
    .out_stride (out_stride),
    .shift      (shift),
    .relu_en    (relu_en),
    .bias_en    (bias_en),
    .bias_addr  (bias_addr),
    .bias_rdata (bias_rdata),
    .out_we     (out_we),
    .out_addr   (out_addr),
    .out_wdata  (out_wdata),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bias_en) bias_rdata <= bias_mem[bias_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int ref_elem(input int a, input int b, input int s, input bit relu);
    int v;
    v = (a + b) >>> s;
    if (relu && v < 0) v = 0;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return v;
  endfunction

  function automatic int unsigned ref_addr(input int unsigned r, input int unsigned c);
    return ((t_row * TD + r) * t_stride + t_col * TD + c) & 32'hFFFF;
  endfunction

  task automatic set_tile(input int a0, input int a1, input int a2, input int a3,
                          input int b0, input int b1, input int unsigned row,
                          input int unsigned col, input int unsigned stride,
                          input int sh, input bit relu);
    t_acc[0] = a0; t_acc[1] = a1; t_acc[2] = a2; t_acc[3] = a3;
    t_bias[0] = b0; t_bias[1] = b1;
    t_row = row; t_col = col; t_stride = stride; t_shift = sh; t_relu = relu;
  endtask

  // Called on a negedge; drives start for one cycle, checks cycles T+1..T+9, returns on T+9's negedge.
  task automatic run_tile(input string name, input bit disturb, input int rst_k);
    int nwr;
    int e, r, c, ev;
    bit live, x_busy, x_done, x_ben, x_we;
    int unsigned ba;
    nwr = 0;
    for (int i = 0; i < NE; i++) acc_in[i*2*DW +: 2*DW] = 16'(t_acc[i]);
    blk_row_idx = t_row;
    blk_col_idx = t_col;
    out_stride  = t_stride;
    shift       = 4'(t_shift);
    relu_en     = t_relu;
    for (int i = 0; i < TD; i++) begin
      ba = (t_col * TD + i) & 32'hFFFF;
      bias_mem[ba] = 8'(t_bias[i]);
    end
    start = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      live   = (rst_k == 0) || (k <= rst_k);
      x_busy = live && k <= TD + NE + 2;
      x_done = live && k == TD + NE + 2;
      x_ben  = live && k <= TD;
      x_we   = live && k >= TD + 2 && k <= TD + 1 + NE;
      check($sformatf("%s@%0d busy", name, k), 32'(busy), 32'(x_busy));
      check($sformatf("%s@%0d done", name, k), 32'(done), 32'(x_done));
      check($sformatf("%s@%0d bias_en", name, k), 32'(bias_en), 32'(x_ben));
      check($sformatf("%s@%0d out_we", name, k), 32'(out_we), 32'(x_we));
      if (x_ben)
        check($sformatf("%s@%0d bias_addr", name, k), 32'(bias_addr),
              (t_col * TD + k - 1) & 32'hFFFF);
      if (x_we) begin
        e  = k - (TD + 2);
        r  = e / TD;
        c  = e % TD;
        ev = ref_elem(t_acc[e], t_bias[c], t_shift, t_relu);
        check($sformatf("%s@%0d out_addr", name, k), 32'(out_addr), ref_addr(r, c));
        check($sformatf("%s@%0d out_wdata", name, k), 32'(out_wdata), 32'(ev & 255));
      end
      if (out_we) nwr++;
      if (k == 1) start = 1'b0;
      if (disturb && k == 1) begin
        acc_in      = {$urandom, $urandom};
        blk_row_idx = $urandom;
        blk_col_idx = $urandom;
        out_stride  = $urandom;
        shift       = 4'($urandom_range(15));
        relu_en     = ~t_relu;
      end
      if (disturb && k == 3) start = 1'b1;
      if (disturb && k == 4) start = 1'b0;
      if (rst_k != 0 && k == rst_k) rstn = 1'b0;
      if (rst_k != 0 && k == rst_k + 2) rstn = 1'b1;
    end
    check($sformatf("%s writes", name), 32'(nwr), (rst_k != 0) ? 32'(rst_k - (TD + 1)) : 32'(NE));
  endtask

  initial begin
    rstn        = 1'b0;
    start       = 1'b1;
    acc_in      = '1;
    blk_row_idx = 32'd3;
    blk_col_idx = 32'd3;
    out_stride  = 32'd7;
    shift       = 4'd0;
    relu_en     = 1'b0;

    repeat (3) begin
      @(negedge clk);
      check("rst busy", 32'(busy), 32'd0);
      check("rst done", 32'(done), 32'd0);
      check("rst out_we", 32'(out_we), 32'd0);
      check("rst bias_en", 32'(bias_en), 32'd0);
      check("rst out_addr", 32'(out_addr), 32'd0);
      check("rst bias_addr", 32'(bias_addr), 32'd0);
      check("rst out_wdata", 32'(out_wdata), 32'd0);
    end
    rstn  = 1'b1;
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post-rst busy", 32'(busy), 32'd0);
      check("post-rst bias_en", 32'(bias_en), 32'd0);
    end

    set_tile(10, 20, 30, 40, 1, -2, 0, 0, 4, 0, 1'b0);
    run_tile("basic", 1'b0, 0);
    @(negedge clk);

    set_tile(1000, -1000, 32767, -32768, 127, 127, 0, 0, 4, 2, 1'b0);
    run_tile("sat", 1'b0, 0);
    set_tile(9, -9, -8, 0, 0, 0, 0, 0, 4, 1, 1'b0);
    run_tile("shift", 1'b0, 0);
    set_tile(9, -9, -8, 0, 0, 0, 0, 0, 4, 1, 1'b1);
    run_tile("relu", 1'b0, 0);

    set_tile(5, 6, 7, 8, 3, 4, 1, 1, 4, 0, 1'b0);
    run_tile("blk11", 1'b0, 0);
    set_tile(-5, 6, -7, 8, -3, 4, 0, 32'h7FFF, 0, 0, 1'b0);
    run_tile("wrap", 1'b0, 0);

    set_tile(100, -200, 300, -400, 50, -60, 2, 3, 16, 1, 1'b0);
    run_tile("snap", 1'b1, 0);
    set_tile(-1, 2, -3, 4, 5, -6, 1, 0, 8, 0, 1'b1);
    run_tile("b2b", 1'b0, 0);

    set_tile(11, 22, 33, 44, 1, 1, 1, 2, 10, 0, 1'b0);
    run_tile("rstmid", 1'b0, 5);
    set_tile(-11, 22, -33, 44, 2, -2, 0, 1, 6, 0, 1'b0);
    run_tile("recover", 1'b0, 0);

    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < NE; i++) t_acc[i] = int'($urandom_range(65535)) - 32768;
      for (int i = 0; i < TD; i++) t_bias[i] = int'($urandom_range(255)) - 128;
      if (n % 4 == 3) begin
        t_row = $urandom; t_col = $urandom; t_stride = $urandom;
      end else begin
        t_row = $urandom_range(50); t_col = $urandom_range(50); t_stride = $urandom_range(300);
      end
      t_shift = int'($urandom_range(15));
      t_relu  = 1'($urandom_range(1));
      run_tile($sformatf("rnd%0d", n), 1'($urandom_range(1)), 0);
      if (n % 3 == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
